// File: rtl/seq_cla_divider_pkg.sv
// Shared types and constants for the sequential CLA divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, counter width helper, lookahead group size.
package seq_cla_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry-lookahead group size used by the trial subtractor.
  localparam int LA_GROUP = 4;

  // Width of the iteration counter; it must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/seq_cla_divider_if.sv
// Request/result bundle between a requester and the divider.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while ready is high; no queueing.
// Ports: start/dividend/divisor from the requester; ready/valid/quotient/
//        remainder/div_by_zero from the divider.
interface seq_cla_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_cla_divider_cla_subtractor.sv
// Combinational a - b as a + ~b + 1 using 4-bit carry-lookahead groups.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b (N bits) in; diff (N bits) and cout (1 = no borrow) out.
module cla_subtractor
  import seq_cla_divider_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  localparam int NG = (N + LA_GROUP - 1) / LA_GROUP;
  localparam int NP = NG * LA_GROUP;

  logic [NP-1:0] a_pad, bn_pad, g, p;
  logic [NG:0]   gc;

  // Carry into bit j of a group, flattened into sum-of-products form so
  // every carry depends only on g/p and the group carry-in.
  function automatic logic la_carry(input logic [LA_GROUP-1:0] gg,
                                    input logic [LA_GROUP-1:0] pp,
                                    input logic cin, input int j);
    logic c, term;
    c = cin;
    for (int i = 0; i < j; i++) c = c & pp[i];
    for (int i = 0; i < j; i++) begin
      term = gg[i];
      for (int m = i + 1; m < j; m++) term = term & pp[m];
      c = c | term;
    end
    return c;
  endfunction

  assign a_pad[N-1:0]  = a;
  assign bn_pad[N-1:0] = ~b;
  // Pad bits propagate (p=1, g=0), so the last group's carry-out equals
  // the carry out of bit N-1.
  if (NP > N) begin : g_pad
    assign a_pad[NP-1:N]  = '0;
    assign bn_pad[NP-1:N] = '1;
  end

  assign g     = a_pad & bn_pad;
  assign p     = a_pad ^ bn_pad;
  assign gc[0] = 1'b1;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    assign gc[k+1] = la_carry(g[k*LA_GROUP +: LA_GROUP], p[k*LA_GROUP +: LA_GROUP],
                              gc[k], LA_GROUP);
    for (genvar j = 0; j < LA_GROUP; j++) begin : g_bit
      if (k * LA_GROUP + j < N) begin : g_real
        assign diff[k*LA_GROUP+j] = p[k*LA_GROUP+j] ^
               la_carry(g[k*LA_GROUP +: LA_GROUP], p[k*LA_GROUP +: LA_GROUP], gc[k], j);
      end
    end
  end

  assign cout = gc[NG];

endmodule

// File: rtl/seq_cla_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Latency: valid WIDTH+1 cycles after accepted start (1 cycle for divide by zero).
// Backpressure: ready only in IDLE; start otherwise ignored, nothing queued.
// Ports: clk, rst (async active-high); bus (slave side of seq_cla_divider_if).
module seq_cla_divider
  import seq_cla_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_cla_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, q_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   s, t;
  logic             no_borrow;
  logic [WIDTH-1:0] p_next, q_next;
  logic             accept, div_zero, last_iter;
  logic             unused_msbs;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign s = {p_q, q_q[WIDTH-1]};

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    (s),
    .b    ({1'b0, d_q}),
    .diff (t),
    .cout (no_borrow)
  );

  // Partial remainder stays below the divisor, so the MSBs are always zero
  // on whichever path is kept.
  assign p_next      = no_borrow ? t[WIDTH-1:0] : s[WIDTH-1:0];
  assign q_next      = {q_q[WIDTH-2:0], no_borrow};
  assign unused_msbs = &{1'b0, t[WIDTH], s[WIDTH]};

  assign accept    = (state_q == IDLE) && bus.start;
  assign div_zero  = (bus.divisor == '0);
  assign last_iter = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = div_zero ? DONE : RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the edge into DONE so valid and data line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          p_q   <= '0;
          q_q   <= bus.dividend;
          d_q   <= bus.divisor;
          cnt_q <= CW'(WIDTH);
          if (div_zero) begin
            quo_q <= '1;
            rem_q <= bus.dividend;
            dbz_q <= 1'b1;
          end
        end
        RUN: begin
          p_q   <= p_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - CW'(1);
          if (last_iter) begin
            quo_q <= q_next;
            rem_q <= p_next;
            dbz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.valid       = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_cla_divider.sv
// Self-checking bench for seq_cla_divider (WIDTH=8).
// Latency: checks valid timing relative to the accepting start edge.
// Backpressure: checks ignored starts in RUN/DONE and async reset abort.
module tb_seq_cla_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  seq_cla_divider_if #(.WIDTH(W)) bus ();

  seq_cla_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           inj;  // cycle at which a stray 50/5 start is pulsed, 0 = none
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, " ready_before_start"}, bus.ready, 1);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_op(input vec_t v, input string name);
    int lat, pulses, ready_bad;
    logic [W-1:0] q, r;
    logic dz;
    wait_ready(name);
    bus.start    = 1'b1;
    bus.dividend = v.dd;
    bus.divisor  = v.dv;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    lat = 0; pulses = 0; ready_bad = 0;
    q = '0; r = '0; dz = 1'b0;
    for (int c = 1; c <= v.lat + 2; c++) begin
      if (v.inj != 0 && c == v.inj) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (c <= v.lat && bus.ready !== 1'b0) ready_bad++;
      if (bus.valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = c; q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, " latency"},   lat, v.lat);
    check({name, " pulses"},    pulses, 1);
    check({name, " ready_low"}, ready_bad, 0);
    check({name, " quotient"},  q, v.q);
    check({name, " remainder"}, r, v.r);
    check({name, " dbz"},       dz, v.dz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c, c2, vcount;
    vec_t rv;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 3};
    vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 0};
    vecs[2] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 9, 0};
    vecs[3] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1, 0};
    vecs[4] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9, 0};
    vecs[5] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1, 0};
    vecs[6] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 9, 0};
    vecs[7] = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0, 9, 0};
    vecs[8] = '{8'd254, 8'd13,  8'd19,  8'd7,   1'b0, 9, 0};

    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1;
    check("reset ready",     bus.ready, 1);
    check("reset valid",     bus.valid, 0);
    check("reset quotient",  bus.quotient, 0);
    check("reset remainder", bus.remainder, 0);
    check("reset dbz",       bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Async reset in the middle of a RUN.
    wait_ready("rst_mid");
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid ready",     bus.ready, 1);
    check("rst_mid valid",     bus.valid, 0);
    check("rst_mid quotient",  bus.quotient, 0);
    check("rst_mid remainder", bus.remainder, 0);
    check("rst_mid dbz",       bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.valid === 1'b1) vcount++;
      @(negedge clk);
    end
    check("rst_mid no_valid", vcount, 0);
    rv = '{8'd77, 8'd10, 8'd7, 8'd7, 1'b0, 9, 0};
    run_op(rv, "after_rst");

    // Back-to-back: start held through DONE must only take effect in IDLE.
    wait_ready("b2b");
    bus.start = 1'b1; bus.dividend = 8'd255; bus.divisor = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (bus.valid !== 1'b1 && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("b2b first latency",   c, 9);
    check("b2b first quotient",  bus.quotient, 255);
    check("b2b first remainder", bus.remainder, 0);
    bus.start = 1'b1; bus.dividend = 8'd255; bus.divisor = 8'd255;
    @(negedge clk);
    check("b2b idle after done", bus.ready, 1);
    @(negedge clk);
    bus.start = 1'b0;
    c2 = 1;
    while (bus.valid !== 1'b1 && c2 < 30) begin
      @(negedge clk);
      c2++;
    end
    check("b2b second latency",   c2, 9);
    check("b2b valid spacing",    c2 + 1, 10);
    check("b2b second quotient",  bus.quotient, 1);
    check("b2b second remainder", bus.remainder, 0);
    check("b2b second dbz",       bus.div_by_zero, 0);
    @(negedge clk);

    // Random sweep against / and % with the divide-by-zero convention.
    for (int i = 0; i < 1500; i++) begin
      rv.dd = W'($urandom);
      rv.dv = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom);
      if (rv.dv == 0) begin
        rv.q = 8'd255; rv.r = rv.dd; rv.dz = 1'b1; rv.lat = 1;
      end else begin
        rv.q = rv.dd / rv.dv; rv.r = rv.dd % rv.dv; rv.dz = 1'b0; rv.lat = 9;
      end
      rv.inj = 0;
      run_op(rv, $sformatf("rand%0d_%0d/%0d", i, rv.dd, rv.dv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
